// File: rtl/hamming_dec74.sv
// Two-stage Hamming(7,4) decoder/corrector with saturating corrected/uncorrectable counters.
// Latency 2 cycles at 1 word/cycle; in_ready drops only when both stages hold words and out_ready is low.
// `define HMC_SECDED_EN enables SEC-DED using in_parity; the default build is SEC only.
module hamming_dec74 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    input  logic             in_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic       r_s1_valid;
    logic [6:0] r_s1_code;
    logic [2:0] r_s1_syn;
    logic       r_s1_pchk;

    logic       r_out_valid;
    logic [3:0] r_out_data;
    logic [2:0] r_out_syn;
    logic       r_out_corr;
    logic       r_out_uncorr;

    logic [CNT_W-1:0] r_corr_cnt;

    logic       w_s2_free;
    logic       w_s1_free;
    logic       w_accept;
    logic       w_deliver;
    logic [2:0] w_syn;
    logic       w_pchk;
    logic [6:0] w_mask;
    logic       w_flip;
    logic       w_corr;
    logic       w_uncorr;
    logic [6:0] w_fixed;

    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;
    assign in_ready  = w_s1_free;
    assign w_accept  = in_valid && w_s1_free;
    assign w_deliver = r_out_valid && out_ready;

    assign w_syn[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
    assign w_syn[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
    assign w_syn[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];

`ifdef HMC_SECDED_EN
    assign w_pchk = (^in_code) ^ in_parity;
`else
    logic w_unused_parity;
    assign w_unused_parity = in_parity;
    assign w_pchk          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_pchk  <= 1'b0;
        end else if (w_s1_free) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_syn;
                r_s1_pchk <= w_pchk;
            end
        end
    end

    // Syndrome value k points at Hamming position k, i.e. code bit k-1.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 7; i++) begin
            w_mask[i] = (r_s1_syn == 3'(i + 1));
        end
    end

`ifdef HMC_SECDED_EN
    // Odd overall parity means an odd number of flips: treat as single and correct.
    assign w_flip   = (|r_s1_syn) && r_s1_pchk;
    assign w_corr   = r_s1_pchk;
    assign w_uncorr = (|r_s1_syn) && !r_s1_pchk;
`else
    assign w_flip   = |r_s1_syn;
    assign w_corr   = |r_s1_syn;
    assign w_uncorr = 1'b0;
`endif

    assign w_fixed = w_flip ? (r_s1_code ^ w_mask) : r_s1_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_syn    <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
                r_out_syn    <= r_s1_syn;
                r_out_corr   <= w_corr;
                r_out_uncorr <= w_uncorr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt <= '0;
        end else if (w_deliver && r_out_corr && (r_corr_cnt != '1)) begin
            r_corr_cnt <= r_corr_cnt + CNT_W'(1);
        end
    end

`ifdef HMC_SECDED_EN
    logic [CNT_W-1:0] r_uncorr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_uncorr_cnt <= '0;
        end else if (w_deliver && r_out_uncorr && (r_uncorr_cnt != '1)) begin
            r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
    end

    assign uncorr_cnt = r_uncorr_cnt;
`else
    assign uncorr_cnt = '0;
`endif

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_syndrome  = r_out_syn;
    assign out_corrected = r_out_corr;
    assign out_uncorr    = r_out_uncorr;
    assign corr_cnt      = r_corr_cnt;

endmodule

// File: tb/tb_hamming_dec74.sv
// Bench for hamming_dec74: vector table through a scoreboard plus stall, reset and saturation sequences.
`timescale 1ns/1ps
module tb_hamming_dec74;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    in_code = '0;
    logic          in_parity = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_data;
    logic [2:0]    out_syndrome;
    logic          out_corrected;
    logic          out_uncorr;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    hamming_dec74 #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_parity(in_parity),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_corrected(out_corrected), .out_uncorr(out_uncorr),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] code;
        logic       par;
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
        logic       unc;
    } vec_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   m_corr = 0;
    int   m_unc = 0;
    vec_t cur_exp;
    vec_t exp_q[$];
    int   acc_q[$];
    int   lat_q[$];
    int   ocyc_q[$];
    logic hold_prev = 1'b0;
    logic [9:0] hold_snap;
    logic t3_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    // Nearest-codeword search; the error position gives the expected syndrome.
    function automatic vec_t model(input logic [6:0] c, input logic p);
        vec_t v;
        int bd;
        int best;
        logic [6:0] diff;
        v = '0;
        v.code = c;
        v.par = p;
        bd = 8;
        best = 0;
        for (int d = 0; d < 16; d++) begin
            if ($countones(c ^ encode(4'(d))) < bd) begin
                bd = $countones(c ^ encode(4'(d)));
                best = d;
            end
        end
        diff = c ^ encode(4'(best));
        for (int i = 0; i < 7; i++) if (diff[i]) v.syn = 3'(i + 1);
        v.data = 4'(best);
        v.corr = (bd == 1);
`ifdef HMC_SECDED_EN
        begin
            logic perr;
            perr = (^c) ^ p;
            if (bd == 0) v.corr = perr;
            else if (!perr) begin
                v.corr = 1'b0;
                v.unc = 1'b1;
                v.data = {c[6], c[5], c[4], c[2]};
            end
        end
`endif
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev && out_valid)
                chk("hold_stable", {out_data, out_syndrome, out_corrected, out_uncorr, 1'b0}, hold_snap);
            hold_prev = out_valid && !out_ready;
            hold_snap = {out_data, out_syndrome, out_corrected, out_uncorr, 1'b0};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_syndrome", out_syndrome, e.syn);
                    chk("out_corrected", out_corrected, e.corr);
                    chk("out_uncorr", out_uncorr, e.unc);
                    lat_q.push_back(cyc - acc_q.pop_front());
                    ocyc_q.push_back(cyc);
                    n_out++;
                    if (!cnt_clr) begin
                        if (e.corr && m_corr < CMAX) m_corr++;
                        if (e.unc && m_unc < CMAX) m_unc++;
                    end
                end
            end
            if (cnt_clr) begin
                m_corr = 0;
                m_unc = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_q.push_back(cyc);
                n_acc++;
            end
        end
    end

    task automatic send(input vec_t v);
        logic acc;
        acc = 1'b0;
        cur_exp = v;
        in_code = v.code;
        in_parity = v.par;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    vec_t tbl[24];

    initial begin
        for (int i = 0; i < 16; i++)
            tbl[i] = {encode(4'(i)), ^encode(4'(i)), 4'(i), 3'd0, 1'b0, 1'b0};
        tbl[16] = {7'b0001001, 1'b1, 4'd2, 3'd5, 1'b1, 1'b0};
`ifdef HMC_SECDED_EN
        tbl[17] = {7'b1111100, 1'b1, 4'd15, 3'd3, 1'b0, 1'b1};
`else
        tbl[17] = {7'b1111100, 1'b1, 4'd14, 3'd3, 1'b1, 1'b0};
`endif
        tbl[18] = model(encode(4'd5), ~(^encode(4'd5)));
        tbl[19] = model(encode(4'd9) ^ 7'b0100100, ^encode(4'd9));
        for (int i = 20; i < 24; i++) begin
            logic [3:0] d;
            logic [6:0] e;
            d = 4'($urandom_range(0, 15));
            e = 7'b1 << $urandom_range(0, 6);
            tbl[i] = model(encode(d) ^ e, ^encode(d));
        end

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bits", {out_data, out_syndrome, out_corrected, out_uncorr}, 0);
        chk("rst_counters", {corr_cnt, uncorr_cnt}, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean codes back-to-back.
        lat_q.delete();
        ocyc_q.delete();
        for (int i = 0; i < 16; i++) send(tbl[i]);
        drain();
        chk("first_latency", lat_q[0], 2);
        chk("burst_span", ocyc_q[15] - ocyc_q[0], 15);
        chk("corr_cnt_clean", corr_cnt, 0);

        send(tbl[16]);
        drain();
        chk("corr_cnt_single", corr_cnt, 1);

        send(tbl[17]);
        drain();
`ifdef HMC_SECDED_EN
        chk("uncorr_cnt_double", uncorr_cnt, 1);
`else
        chk("uncorr_cnt_double", uncorr_cnt, 0);
`endif
        for (int i = 18; i < 24; i++) send(tbl[i]);
        drain();
        chk("corr_cnt_model", corr_cnt, m_corr);
        chk("uncorr_cnt_model", uncorr_cnt, m_unc);

        // Backpressure: two words fit, the third waits.
        out_ready = 1'b0;
        begin
            int a0;
            int o0;
            a0 = n_acc;
            o0 = n_out;
            fork
                begin
                    send(tbl[3]);
                    send(tbl[7]);
                    send(tbl[11]);
                    t3_done = 1'b1;
                end
            join_none
            repeat (6) @(posedge clk);
            #1;
            chk("stall_accepted", n_acc - a0, 2);
            chk("stall_in_ready", in_ready, 0);
            out_ready = 1'b1;
            for (int k = 0; k < 100 && !t3_done; k++) @(posedge clk);
            chk("stall_sender_done", t3_done, 1);
            #1;
            drain();
            chk("stall_delivered", n_out - o0, 3);
        end

        // Reset with both stages full.
        out_ready = 1'b0;
        send(tbl[16]);
        send(tbl[5]);
        @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_counters", {corr_cnt, uncorr_cnt}, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        m_corr = 0;
        m_unc = 0;
        hold_prev = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int o0;
            o0 = n_out;
            lat_q.delete();
            send(tbl[9]);
            drain();
            chk("post_rst_latency", lat_q[0], 2);
            chk("post_rst_count", n_out - o0, 1);
        end

        // Counter saturation, then clear colliding with a delivery.
        for (int i = 0; i < 5; i++) send(model(encode(4'(i + 3)) ^ (7'b1 << i), ^encode(4'(i + 3))));
        drain();
        chk("corr_cnt_saturated", corr_cnt, CMAX);
        chk("corr_cnt_sat_model", corr_cnt, m_corr);
        out_ready = 1'b0;
        send(tbl[16]);
        @(posedge clk);
        #1;
        chk("clr_pre_out_valid", out_valid, 1);
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("corr_cnt_cleared", corr_cnt, 0);
        chk("corr_cnt_clr_model", corr_cnt, m_corr);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule
